float_adder_arbiter: RTL and testbench

- Shares one multi-cycle bf16 float adder among N_REQ requesters using round-robin arbitration.
- Each operation runs in sequence: latch operands, restart the adder, wait for its valid, then return the sum tagged with the requester id over a valid/ready response channel.
- A cycle watchdog guarantees forward progress if the adder never signals valid.
- Sits between the requesting compute lanes and a single float_adder_bf16 instance.

---
 rtl/float_adder_arbiter.sv | 175 +++++++++++++++++
 tb/tb_float_adder_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/float_adder_arbiter.sv
// rtl/float_adder_arbiter.sv - round-robin sharing of one multi-cycle bf16 adder
//
// Ports:
//   clock, reset_n              system clock, asynchronous active-low reset
//   req_valid/req_a/req_b       per-requester operands (slice i = requester i)
//   req_ready                   one-hot accept, only while idle
//   resp_valid/resp_ready       result handshake; resp_y, resp_id, resp_timeout
//   adder_a/adder_b             operands to the shared adder, held for the op
//   adder_reset                 active-high restart to the adder
//   adder_y/adder_valid         result from the shared adder
module float_adder_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int MAX_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_y,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_timeout,
    output logic [15:0]           adder_a,
    output logic [15:0]           adder_b,
    output logic                  adder_reset,
    input  logic [15:0]           adder_y,
    input  logic                  adder_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ID_W:0] N_EXT    = (ID_W+1)'(N_REQ);
    localparam logic [7:0]    CNT_LAST = 8'(MAX_CYCLES - 1);

    state_t          state;
    state_t          state_n;
    logic [ID_W-1:0] ptr;
    logic [7:0]      cnt;

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;
    logic [ID_W:0]    sum;
    logic [ID_W:0]    sum_next;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  win_next;
    logic             any;
    logic             accept;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic             expire;

    // Rotate the request vector so that index ptr sits at bit 0; the lowest
    // set bit of the rotated vector is then the round-robin winner offset.
    always_comb begin
        rot = N_REQ'({req_valid, req_valid} >> ptr);
        any = |rot;
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        win      = sum[ID_W-1:0];
        sum_next = {1'b0, win} + {{ID_W{1'b0}}, 1'b1};
        if (sum_next >= N_EXT) begin
            sum_next = '0;
        end
        win_next = sum_next[ID_W-1:0];
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    assign accept = (state == S_IDLE) && any;
    assign expire = (cnt == CNT_LAST);

    // req_ready depends on the live req_valid input, so it is also gated by
    // reset_n to stay low while the arbiter is held in reset.
    always_comb begin
        state_n     = state;
        req_ready   = '0;
        resp_valid  = 1'b0;
        adder_reset = 1'b1;
        case (state)
            S_IDLE: begin
                if (any && reset_n) begin
                    req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                end
                if (accept) begin
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                adder_reset = 1'b0;
                state_n     = S_RUN;
            end
            S_RUN: begin
                adder_reset = 1'b0;
                if (adder_valid || expire) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            cnt          <= '0;
            adder_a      <= '0;
            adder_b      <= '0;
            resp_y       <= '0;
            resp_id      <= '0;
            resp_timeout <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        adder_a <= sel_a;
                        adder_b <= sel_b;
                        resp_id <= win;
                        ptr     <= win_next;
                    end
                end
                S_LAUNCH: begin
                    cnt <= '0;
                end
                S_RUN: begin
                    cnt <= cnt + 8'd1;
                    // A result arriving on the expiry cycle still wins.
                    if (adder_valid) begin
                        resp_y       <= adder_y;
                        resp_timeout <= 1'b0;
                    end else if (expire) begin
                        resp_y       <= '0;
                        resp_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_adder_arbiter.sv
// tb/tb_float_adder_arbiter.sv - directed self-checking bench for float_adder_arbiter
module tb_float_adder_arbiter;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_y;
    logic [1:0]  resp_id;
    logic        resp_timeout;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic        adder_reset;
    logic [15:0] adder_y;
    logic        adder_valid;

    int total = 0;
    int bad   = 0;

    float_adder_arbiter #(.N_REQ(4), .ID_W(2), .MAX_CYCLES(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_y      (resp_y),
        .resp_id     (resp_id),
        .resp_timeout(resp_timeout),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_reset (adder_reset),
        .adder_y     (adder_y),
        .adder_valid (adder_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Adder model: result valid two cycles after restart is released,
    // sums from a small table of hand-computed bf16 values.
    logic [7:0] mcnt;
    bit         stall;

    always @(posedge clock) begin
        if (adder_reset) mcnt <= 8'd0;
        else if (mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
    end

    function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3F80 && b == 16'h3F80) return 16'h4000;
        if (a == 16'h3F80 && b == 16'h4000) return 16'h4040;
        return 16'hFFFF;
    endfunction

    assign adder_valid = !adder_reset && !stall && (mcnt >= 8'd2);
    assign adder_y     = model_sum(adder_a, adder_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the requests already set up.
    task automatic run_op(input string tag, input logic [3:0] exp_rdy, input logic [1:0] exp_id,
                          input logic [15:0] exp_y, input logic exp_to, input int exp_lat,
                          input bit clr, input int bp);
        int lat;
        int waited;
        bit stable;
        #1;
        waited = 0;
        while (req_ready == 4'b0000 && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        chk({tag, "_grant"}, {28'd0, req_ready}, {28'd0, exp_rdy});
        @(posedge clock);
        #1;
        if (clr) req_valid = 4'b0000;
        lat = 0;
        while (lat < 200) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (resp_valid) break;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_resp_y"}, {16'd0, resp_y}, {16'd0, exp_y});
        chk({tag, "_resp_id"}, {30'd0, resp_id}, {30'd0, exp_id});
        chk({tag, "_timeout"}, {31'd0, resp_timeout}, {31'd0, exp_to});
        chk({tag, "_ready_busy"}, {28'd0, req_ready}, 32'd0);
        if (bp > 0) begin
            stable = 1'b1;
            repeat (bp) begin
                @(negedge clock);
                if (!(resp_valid && resp_y == exp_y && resp_id == exp_id && req_ready == 4'b0000))
                    stable = 1'b0;
            end
            chk({tag, "_bp_stable"}, {31'd0, stable}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        @(negedge clock);
        chk({tag, "_resp_drop"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        stall      = 1'b0;
        resp_ready = 1'b0;
        reset_n    = 1'b0;
        req_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'h3F80;
            req_b[16*i +: 16] = 16'h4000;
        end

        // Reset values, with all requests already valid.
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_y", {16'd0, resp_y}, 32'd0);
        chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
        chk("rst_timeout", {31'd0, resp_timeout}, 32'd0);
        chk("rst_adder_ab", {adder_a, adder_b}, 32'd0);
        chk("rst_adder_reset", {31'd0, adder_reset}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // All four continuously valid: grants 0,1,2,3.
        run_op("rr0", 4'b0001, 2'd0, 16'h4040, 1'b0, 3, 1'b0, 0);
        run_op("rr1", 4'b0010, 2'd1, 16'h4040, 1'b0, 3, 1'b0, 0);
        run_op("rr2", 4'b0100, 2'd2, 16'h4040, 1'b0, 3, 1'b0, 0);
        run_op("rr3", 4'b1000, 2'd3, 16'h4040, 1'b0, 3, 1'b0, 0);

        // Pointer wrap: after granting 3, both 0 and 3 valid -> 0 first.
        req_valid = 4'b1001;
        run_op("wrap", 4'b0001, 2'd0, 16'h4040, 1'b0, 3, 1'b1, 0);

        // Single request from requester 0 (ptr=1, scan wraps to 0): 1.0+1.0.
        req_a[15:0] = 16'h3F80;
        req_b[15:0] = 16'h3F80;
        req_valid   = 4'b0001;
        run_op("single", 4'b0001, 2'd0, 16'h4000, 1'b0, 3, 1'b1, 0);

        // Backpressure for 10 cycles on requester 2.
        req_b[47:32] = 16'h3F80;
        req_valid    = 4'b0100;
        run_op("bp", 4'b0100, 2'd2, 16'h4000, 1'b0, 3, 1'b1, 10);

        // Watchdog: adder never valid -> 1 LAUNCH + 16 RUN cycles, y forced 0.
        stall        = 1'b1;
        req_b[31:16] = 16'h3F80;
        req_valid    = 4'b0010;
        run_op("wdog", 4'b0010, 2'd1, 16'h0000, 1'b1, 17, 1'b1, 0);

        // Reset mid-RUN on an operation from requester 3 (ptr=2).
        req_valid = 4'b1000;
        #1;
        chk("abort_grant", {28'd0, req_ready}, 32'h8);
        @(posedge clock);
        #1;
        req_valid = 4'b0000;
        repeat (5) @(negedge clock);
        chk("abort_in_run", {31'd0, adder_reset}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_async", {resp_valid, adder_reset, resp_timeout, req_ready, resp_id, 8'd0, resp_y},
            {1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, 8'd0, 16'h0000});
        chk("abort_adder_ab", {adder_a, adder_b}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        stall   = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);

        // After reset ptr=0; only requester 2 valid -> granted.
        req_b[47:32] = 16'h4000;
        req_valid    = 4'b0100;
        run_op("post_rst", 4'b0100, 2'd2, 16'h4040, 1'b0, 3, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
